// File: rtl/falu_issue_seq.sv
// Issue/writeback sequencer for the combinational FP ALU. It holds the operands on the FALU
// for a per-op cycle budget, captures the result and flags, and keeps sticky flags for the CSR block.
module falu_issue_seq #(
    parameter int unsigned ADDSUB_CYCLES = 2,
    parameter int unsigned MUL_CYCLES    = 3,
    parameter int unsigned DIV_CYCLES    = 8,
    parameter int unsigned CMP_CYCLES    = 1,
    parameter int unsigned RD_W          = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [RD_W-1:0] req_rd,
    output logic [31:0]     falu_a,
    output logic [31:0]     falu_b,
    output logic [3:0]      falu_op,
    input  logic [31:0]     falu_result,
    input  logic            falu_exception,
    input  logic            falu_overflow,
    input  logic            falu_underflow,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [RD_W-1:0] rsp_rd,
    output logic [2:0]      rsp_flags,
    output logic [2:0]      flags_sticky,
    input  logic            flags_clr
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // The counter holds cycles remaining minus one, so it expires at zero.
    localparam logic [3:0] ADDSUB_LAST = 4'(ADDSUB_CYCLES - 1);
    localparam logic [3:0] MUL_LAST    = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST    = 4'(DIV_CYCLES - 1);
    localparam logic [3:0] CMP_LAST    = 4'(CMP_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [RD_W-1:0] r_rd;
    logic [31:0]     r_rsp_data;
    logic [2:0]      r_rsp_flags;
    logic [2:0]      r_sticky;

    logic            w_accept;
    logic            w_op_legal;
    logic            w_capture;
    logic [3:0]      w_cnt_init;
    logic [2:0]      w_new_flags;

    assign req_ready  = (r_state == IDLE) && !flush;
    assign w_accept   = req_valid && req_ready;
    assign w_op_legal = (req_op <= 4'd6);
    // Flush beats counter expiry, so an aborted op never reaches the result or sticky flags.
    assign w_capture  = (r_state == EXEC) && (r_cnt == 4'd0) && !flush;

    assign w_new_flags = w_capture                 ? {falu_exception, falu_overflow, falu_underflow} :
                         (w_accept && !w_op_legal) ? 3'b100 : 3'b000;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_cnt_init = 4'd0;
        case (req_op)
            4'd0, 4'd1:       w_cnt_init = ADDSUB_LAST;
            4'd2:             w_cnt_init = MUL_LAST;
            4'd3:             w_cnt_init = DIV_LAST;
            4'd4, 4'd5, 4'd6: w_cnt_init = CMP_LAST;
            default:          w_cnt_init = 4'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_op_legal ? EXEC : DONE;
            EXEC: begin
                if (flush)               w_state_nxt = IDLE;
                else if (r_cnt == 4'd0)  w_state_nxt = DONE;
            end
            DONE: if (flush || rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_cnt       <= 4'd0;
            r_op        <= 4'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_rd        <= '0;
            r_rsp_data  <= 32'd0;
            r_rsp_flags <= 3'b000;
            r_sticky    <= 3'b000;
        end else begin
            // A flag set on the same edge as a clear survives.
            r_sticky <= (flags_clr ? 3'b000 : r_sticky) | w_new_flags;
            if (w_accept) begin
                r_a   <= req_a;
                r_b   <= req_b;
                r_op  <= req_op;
                r_rd  <= req_rd;
                r_cnt <= w_cnt_init;
                if (!w_op_legal) begin
                    r_rsp_data  <= 32'd0;
                    r_rsp_flags <= 3'b100;
                end
            end else if (w_capture) begin
                r_rsp_data  <= falu_result;
                r_rsp_flags <= {falu_exception, falu_overflow, falu_underflow};
            end else if (r_state == EXEC && !flush) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign falu_a       = (r_state == EXEC) ? r_a  : 32'd0;
    assign falu_b       = (r_state == EXEC) ? r_b  : 32'd0;
    assign falu_op      = (r_state == EXEC) ? r_op : 4'd15;
    assign rsp_valid    = (r_state == DONE);
    assign rsp_data     = r_rsp_data;
    assign rsp_rd       = r_rd;
    assign rsp_flags    = r_rsp_flags;
    assign flags_sticky = r_sticky;

endmodule

// File: tb/tb_falu_issue_seq.sv
// Scoreboard bench for falu_issue_seq: a small FALU model answers the held operands and
// every response handshake is compared against the expectation queued at issue time.
module tb_falu_issue_seq;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [2:0]  flags;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic [31:0] falu_a;
    logic [31:0] falu_b;
    logic [3:0]  falu_op;
    logic [31:0] falu_result;
    logic        falu_exception;
    logic        falu_overflow;
    logic        falu_underflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [2:0]  rsp_flags;
    logic [2:0]  flags_sticky;
    logic        flags_clr;

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t sb[$];

    always #5 CLK = ~CLK;

    falu_issue_seq dut (
        .CLK(CLK), .RESET_N(RESET_N), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .falu_a(falu_a), .falu_b(falu_b), .falu_op(falu_op),
        .falu_result(falu_result), .falu_exception(falu_exception),
        .falu_overflow(falu_overflow), .falu_underflow(falu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_flags(rsp_flags),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr)
    );

    // FALU stand-in: exact answers for the vectors used here; compares treat operands as positive floats.
    always_comb begin
        falu_result    = falu_a ^ falu_b;
        falu_exception = 1'b0;
        falu_overflow  = 1'b0;
        falu_underflow = 1'b0;
        case (falu_op)
            4'd0: if (falu_a == 32'h3FC00000 && falu_b == 32'h40100000) falu_result = 32'h40700000;
            4'd2: if (falu_a == 32'h7F000000 && falu_b == 32'h7F000000) begin
                falu_result   = 32'h7F800000;
                falu_overflow = 1'b1;
            end
            4'd3: if (falu_a == 32'h3F800000 && falu_b == 32'h40800000) falu_result = 32'h3E800000;
            4'd4: falu_result = {31'd0, falu_a <= falu_b};
            4'd5: falu_result = {31'd0, falu_a <  falu_b};
            4'd6: falu_result = {31'd0, falu_a == falu_b};
            default: falu_result = 32'd0;
        endcase
    end

    // Response side of the scoreboard.
    always @(negedge CLK) begin
        if (RESET_N && rsp_valid && rsp_ready && !flush) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL rsp_unexpected: got data=%h rd=%0d flags=%b, expected no response",
                         rsp_data, rsp_rd, rsp_flags);
            end else begin
                rsp_t exp_r;
                exp_r = sb.pop_front();
                if ({rsp_data, rsp_rd, rsp_flags} !== {exp_r.data, exp_r.rd, exp_r.flags}) begin
                    n_errors++;
                    $display("FAIL rsp_payload: got data=%h rd=%0d flags=%b, expected data=%h rd=%0d flags=%b",
                             rsp_data, rsp_rd, rsp_flags, exp_r.data, exp_r.rd, exp_r.flags);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Presents one request; returns just after the handshake edge.
    task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // Counts cycles after the handshake until rsp_valid (-1 on timeout) and the
    // cycles in which the FALU saw exactly this op and these operands.
    task automatic wait_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output int busy);
        lat  = -1;
        busy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (falu_op == op && falu_a == a && falu_b == b) busy++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 4'd0;
        req_a = 32'd0; req_b = 32'd0; req_rd = 5'd0; rsp_ready = 1'b1; flags_clr = 1'b0;
        repeat (2) step();
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_rd, rsp_flags, flags_sticky, falu_op, falu_a, falu_b, req_ready} !==
            {1'b0, 32'd0, 5'd0, 3'd0, 3'd0, 4'd15, 32'd0, 32'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%b data=%h rd=%0d flags=%b sticky=%b fop=%0d ready=%b, expected 0/0/0/0/0/15/1",
                     rsp_valid, rsp_data, rsp_rd, rsp_flags, flags_sticky, falu_op, req_ready);
        end
        RESET_N = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat, busy;
        sb.push_back('{data: 32'h40700000, rd: 5'd5, flags: 3'b000});
        drive_req(4'd0, 32'h3FC00000, 32'h40100000, 5'd5);
        wait_rsp(4'd0, 32'h3FC00000, 32'h40100000, lat, busy);
        n_checks++;
        if (lat !== 3) begin n_errors++; $display("FAIL add_latency: got %0d, expected 3", lat); end
        n_checks++;
        if (busy !== 2) begin n_errors++; $display("FAIL add_exec_cycles: got %0d, expected 2", busy); end
        step();
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, req_ready, falu_op} !== {1'b0, 1'b1, 4'd15}) begin
            n_errors++;
            $display("FAIL add_after_hs: got valid=%b ready=%b fop=%0d, expected 0 1 15", rsp_valid, req_ready, falu_op);
        end
        step();
    endtask

    task automatic test_div_backpressure();
        int lat, busy;
        rsp_ready = 1'b0;
        sb.push_back('{data: 32'h3E800000, rd: 5'd9, flags: 3'b000});
        drive_req(4'd3, 32'h3F800000, 32'h40800000, 5'd9);
        wait_rsp(4'd3, 32'h3F800000, 32'h40800000, lat, busy);
        n_checks++;
        if (lat !== 9) begin n_errors++; $display("FAIL div_latency: got %0d, expected 9", lat); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin step(); @(negedge CLK); end
            n_checks++;
            if ({rsp_valid, rsp_data, rsp_rd, req_ready} !== {1'b1, 32'h3E800000, 5'd9, 1'b0}) begin
                n_errors++;
                $display("FAIL div_hold%0d: got valid=%b data=%h rd=%0d ready=%b, expected 1 3e800000 9 0",
                         i, rsp_valid, rsp_data, rsp_rd, req_ready);
            end
        end
        step();
        rsp_ready = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL div_hs_cycle: got valid=%b ready=%b, expected 1 0", rsp_valid, req_ready);
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL div_after_hs: got valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
        end
        step();
    endtask

    task automatic test_compare();
        int lat, busy;
        sb.push_back('{data: 32'h00000001, rd: 5'd1, flags: 3'b000});
        drive_req(4'd5, 32'h3F800000, 32'h40000000, 5'd1);
        wait_rsp(4'd5, 32'h3F800000, 32'h40000000, lat, busy);
        n_checks++;
        if (lat !== 2) begin n_errors++; $display("FAIL lt_latency: got %0d, expected 2", lat); end
        step();
        sb.push_back('{data: 32'h00000000, rd: 5'd2, flags: 3'b000});
        drive_req(4'd6, 32'h3F800000, 32'h40000000, 5'd2);
        wait_rsp(4'd6, 32'h3F800000, 32'h40000000, lat, busy);
        n_checks++;
        if (lat !== 2 || busy !== 1) begin
            n_errors++;
            $display("FAIL eq_timing: got lat=%0d busy=%0d, expected 2 1", lat, busy);
        end
        step();
    endtask

    task automatic test_overflow_sticky();
        int lat, busy;
        sb.push_back('{data: 32'h7F800000, rd: 5'd3, flags: 3'b010});
        drive_req(4'd2, 32'h7F000000, 32'h7F000000, 5'd3);
        wait_rsp(4'd2, 32'h7F000000, 32'h7F000000, lat, busy);
        n_checks++;
        if (lat !== 4 || flags_sticky !== 3'b010) begin
            n_errors++;
            $display("FAIL mul_ovf: got lat=%0d sticky=%b, expected 4 010", lat, flags_sticky);
        end
        step();
        sb.push_back('{data: 32'h40700000, rd: 5'd4, flags: 3'b000});
        drive_req(4'd0, 32'h3FC00000, 32'h40100000, 5'd4);
        wait_rsp(4'd0, 32'h3FC00000, 32'h40100000, lat, busy);
        n_checks++;
        if (flags_sticky !== 3'b010) begin
            n_errors++; $display("FAIL sticky_kept: got %b, expected 010", flags_sticky);
        end
        step();
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (flags_sticky !== 3'b000) begin
            n_errors++; $display("FAIL sticky_clr: got %b, expected 000", flags_sticky);
        end
        step();
        // Clear held across the whole op, including the capture edge.
        flags_clr = 1'b1;
        sb.push_back('{data: 32'h7F800000, rd: 5'd6, flags: 3'b010});
        drive_req(4'd2, 32'h7F000000, 32'h7F000000, 5'd6);
        wait_rsp(4'd2, 32'h7F000000, 32'h7F000000, lat, busy);
        flags_clr = 1'b0;
        n_checks++;
        if (flags_sticky !== 3'b010) begin
            n_errors++; $display("FAIL sticky_clr_and_set: got %b, expected 010", flags_sticky);
        end
        step();
    endtask

    task automatic test_flush();
        drive_req(4'd3, 32'h3F800000, 32'h40800000, 5'd10);
        repeat (3) step();
        flush = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b, expected 0", req_ready); end
        step();
        flush = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({req_ready, rsp_valid, flags_sticky} !== {1'b1, 1'b0, 3'b010}) begin
            n_errors++;
            $display("FAIL flush_after: got ready=%b valid=%b sticky=%b, expected 1 0 010", req_ready, rsp_valid, flags_sticky);
        end
        // Flush while idle blocks acceptance.
        step();
        flush = 1'b1;
        req_op = 4'd0; req_a = 32'h3FC00000; req_b = 32'h40100000; req_valid = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 1'b0) begin n_errors++; $display("FAIL flush_idle_ready: got %b, expected 0", req_ready); end
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, falu_op} !== {1'b0, 4'd15}) begin
            n_errors++; $display("FAIL flush_idle_accept: got valid=%b fop=%0d, expected 0 15", rsp_valid, falu_op);
        end
        // Flush on the capture cycle of an overflowing mul.
        step();
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        drive_req(4'd2, 32'h7F000000, 32'h7F000000, 5'd11);
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({flags_sticky, rsp_valid, req_ready} !== {3'b000, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL flush_capture: got sticky=%b valid=%b ready=%b, expected 000 0 1", flags_sticky, rsp_valid, req_ready);
        end
        n_checks++;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (rsp_valid) seen++;
                step();
                @(negedge CLK);
            end
            if (seen !== 0) begin n_errors++; $display("FAIL flush_no_rsp: got %0d valid cycles, expected 0", seen); end
        end
        step();
    endtask

    task automatic test_illegal();
        int lat, busy;
        sb.push_back('{data: 32'h00000000, rd: 5'd7, flags: 3'b100});
        drive_req(4'd9, 32'h12345678, 32'h9ABCDEF0, 5'd7);
        wait_rsp(4'd9, 32'h12345678, 32'h9ABCDEF0, lat, busy);
        n_checks++;
        if (lat !== 1 || busy !== 0) begin
            n_errors++; $display("FAIL illegal_timing: got lat=%0d busy=%0d, expected 1 0", lat, busy);
        end
        n_checks++;
        if ({falu_op, flags_sticky} !== {4'd15, 3'b100}) begin
            n_errors++; $display("FAIL illegal_state: got fop=%0d sticky=%b, expected 15 100", falu_op, flags_sticky);
        end
        step();
    endtask

    task automatic test_reset_mid_exec();
        int lat, busy;
        sb.push_back('{data: 32'h40700000, rd: 5'd12, flags: 3'b000});
        drive_req(4'd0, 32'h3FC00000, 32'h40100000, 5'd12);
        wait_rsp(4'd0, 32'h3FC00000, 32'h40100000, lat, busy);
        step();
        drive_req(4'd3, 32'h3F800000, 32'h40800000, 5'd13);
        repeat (2) step();
        RESET_N = 1'b0;
        step();
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_rd, rsp_flags, flags_sticky, falu_op, falu_a, req_ready} !==
            {1'b0, 32'd0, 5'd0, 3'd0, 3'd0, 4'd15, 32'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_mid_exec: got valid=%b data=%h rd=%0d flags=%b sticky=%b fop=%0d ready=%b, expected 0/0/0/0/0/15/1",
                     rsp_valid, rsp_data, rsp_rd, rsp_flags, flags_sticky, falu_op, req_ready);
        end
        RESET_N = 1'b1;
        repeat (12) step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_div_backpressure();
        test_compare();
        test_overflow_sticky();
        test_flush();
        test_illegal();
        test_reset_mid_exec();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL sb_drained: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/falu_issue_seq.md
Name: falu_issue_seq

Overview:
- Multi-cycle issue/writeback sequencer wrapped around the combinational floating-point ALU (FALU) in the RV32IM pipeline's FP execute path.
- Accepts one FP request from the ID/EX stage via valid/ready.
- Holds the operands and op code stable on the FALU inputs for a per-operation cycle budget, since the combinational divide and multiply paths cannot close timing in one cycle.
- Registers the result and exception flags, then presents them to the writeback stage via valid/ready.
- Also maintains sticky FP exception flags for the CSR block.

Parameters:
- ADDSUB_CYCLES, 2: EXEC cycles for op 0 (add) and op 1 (sub); legal range 1..15.
- MUL_CYCLES, 3: EXEC cycles for op 2 (mul); legal range 1..15.
- DIV_CYCLES, 8: EXEC cycles for op 3 (div); legal range 1..15.
- CMP_CYCLES, 1: EXEC cycles for ops 4 (le), 5 (lt) and 6 (eq); legal range 1..15.
- RD_W, 5: destination register tag width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  reset; synchronous, active-low.
- flush  in  1  pipeline flush; aborts any in-flight op.
- req_valid  in  1  request valid.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  op code: 0 add, 1 sub, 2 mul, 3 div, 4 le, 5 lt, 6 eq.
- req_a  in  32  operand A (IEEE-754 single).
- req_b  in  32  operand B.
- req_rd  in  RD_W  destination tag.
- falu_a  out  32  operand A to FALU.
- falu_b  out  32  operand B to FALU.
- falu_op  out  4  op code to FALU.
- falu_result  in  32  FALU result.
- falu_exception  in  1  FALU exception flag.
- falu_overflow  in  1  FALU overflow flag.
- falu_underflow  in  1  FALU underflow flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  writeback can take the response.
- rsp_data  out  32  captured result.
- rsp_rd  out  RD_W  destination tag.
- rsp_flags  out  3  {exception, overflow, underflow} for this op.
- flags_sticky  out  3  accumulated {exception, overflow, underflow}.
- flags_clr  in  1  clear flags_sticky (CSR write).

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- Reset (RESET_N=0 at a clock edge): state=IDLE, counter=0, all latched regs=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_flags=0, flags_sticky=0.
  - Reset applied mid-EXEC or mid-DONE discards the op; no response is produced.
- req_ready = 1 only in IDLE, and only when flush=0. Combinational from state and flush.
- IDLE, on req_valid & req_ready:
  - Latch req_a, req_b, req_op, req_rd.
  - Legal op (0..6): load counter with the op's cycle count minus 1; go to EXEC.
  - Illegal op (7..15): go directly to DONE with rsp_data=0 and rsp_flags=3'b100. flags_sticky[2] is set.
- EXEC:
  - falu_a, falu_b and falu_op are driven from the latched regs and stay stable for the whole state.
  - Counter decrements each cycle.
  - In the cycle where counter==0: capture falu_result into rsp_data, and {falu_exception, falu_overflow, falu_underflow} into rsp_flags; go to DONE.
- Outside EXEC: falu_op=4'd15 (no FALU path selected), falu_a=0, falu_b=0.
- Latency: handshake in cycle t; EXEC occupies cycles t+1..t+N (N = op cycle count); rsp_valid rises in cycle t+N+1.
- DONE:
  - rsp_valid=1. rsp_data, rsp_rd and rsp_flags are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE and drop rsp_valid.
  - A new request is not accepted in the same cycle as the response handshake; minimum issue interval is N+2 cycles.
- Compare ops: FALU returns 0 or 1 in bit 0; the result is passed through unchanged (bits 31:1 = 0).
- flags_sticky update per edge: next = (flags_clr ? 0 : flags_sticky) | captured_flags.
  - captured_flags is nonzero only on the EXEC->DONE capture edge, or on illegal-op acceptance.
  - A flag that is cleared and set in the same cycle ends up set.
- flush=1, state EXEC or DONE: go to IDLE next edge; rsp_valid=0; flags_sticky gets no update from the aborted op; a pending capture that same cycle is discarded.
- flush=1, state IDLE: the request is not accepted (req_ready=0).
- flush has priority over rsp_ready and over counter expiry.
- The counter is 4 bits. A parameter value of 0 is illegal; the bench shall not use it.

Test Plan:
- Add, default params: op0, A=0x3FC00000 (1.5), B=0x40100000 (2.25), rsp_ready=1 -> rsp_valid 3 cycles after handshake; rsp_data=0x40700000; rsp_flags=0; falu_op=0 during exactly 2 cycles.
- Div with backpressure: op3, A=0x3F800000, B=0x40800000, rsp_ready held 0 for 5 cycles -> rsp_valid at t+9; rsp_data=0x3E800000 held stable; req_ready=0 until the cycle after the rsp handshake.
- Compare: op5, A=0x3F800000, B=0x40000000 -> rsp_data=0x00000001 at t+2. Then op6 with the same operands -> rsp_data=0x00000000.
- Overflow sticky: op2, A=B=0x7F000000 -> rsp_flags[1]=1 and flags_sticky=3'b?1? after capture. A following clean add leaves the bit set. flags_clr pulse -> flags_sticky=0. flags_clr asserted on a capture edge -> new flags retained.
- Flush: issue op3, assert flush at EXEC cycle 4 -> no rsp_valid ever; flags_sticky unchanged; req_ready=1 the cycle after flush deasserts.
- Illegal op 9 -> rsp_valid at t+1; rsp_data=0; rsp_flags=3'b100; falu_op stays 15. Also: RESET_N=0 mid-EXEC -> all outputs at reset values on the next edge.
